// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the instruction fetch unit
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INCR          = 4;

    // Counters must hold 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry {pc, instr} queue with synchronous flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_pc_in,
    input  logic [WIDTH-1:0] push_instr_in,
    input  logic             pop_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [CW-1:0]    count_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_in && (count_q != '0);
    assign do_push = push_in && ((count_q != CW'(DEPTH)) || do_pop);

    // Flush drops everything, including a push or pop requested in the same cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (flush_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                pc_mem_q[wr_ptr_q]    <= push_pc_in;
                instr_mem_q[wr_ptr_q] <= push_instr_in;
                wr_ptr_q              <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign valid_out = (count_q != '0);
    assign pc_out    = pc_mem_q[rd_ptr_q];
    assign instr_out = instr_mem_q[rd_ptr_q];
    assign count_out = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect and stale-response discard
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pc_src_in,
    input  logic [WIDTH-1:0] pc_branch_in,
    output logic             imem_req_valid_out,
    input  logic             imem_req_ready_in,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_rsp_valid_in,
    input  logic [WIDTH-1:0] imem_rsp_data_in,
    output logic             instr_valid_out,
    input  logic             instr_ready_in,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc_out,
    output logic [WIDTH-1:0] pc_current_out
);

    localparam int               CW         = cnt_width(DEPTH);
    localparam logic [CW:0]      CREDIT_LIM = (CW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] INCR       = WIDTH'(PC_INCR);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    discard_q, discard_d;
    logic [CW-1:0]    queue_count;
    logic [WIDTH-1:0] target;
    logic             req_fire;
    logic             rsp_keep;
    logic             pop;

    assign target = pc_branch_in & ~WIDTH'(3);

    // Every outstanding request owns a queue slot, so a response can always be accepted.
    assign imem_req_valid_out = rst_in && !pc_src_in &&
                                (({1'b0, queue_count} + {1'b0, inflight_q}) < CREDIT_LIM);
    assign req_fire           = imem_req_valid_out && imem_req_ready_in;
    assign rsp_keep           = imem_rsp_valid_in && !pc_src_in && (discard_q == '0);
    assign pop                = instr_valid_out && instr_ready_in && !pc_src_in;

    assign imem_addr_out  = pc_q;
    assign pc_current_out = pc_q;

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_in);
        if (pc_src_in) begin
            // Everything still outstanding is stale; a response arriving now is dropped here.
            pc_d      = target;
            rsp_pc_d  = target;
            discard_d = inflight_q - CW'(imem_rsp_valid_in);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + INCR;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + INCR;
            end else if (imem_rsp_valid_in) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (pc_src_in),
        .push_in       (rsp_keep),
        .push_pc_in    (rsp_pc_q),
        .push_instr_in (imem_rsp_data_in),
        .pop_in        (pop),
        .valid_out     (instr_valid_out),
        .pc_out        (instr_pc_out),
        .instr_out     (instr_out),
        .count_out     (queue_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: address and instruction width.
REQ-002 Parameter DEPTH, default 4: fetch-queue entries and maximum in-flight requests; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-004 clk_in  input  1: single clock, rising edge.
REQ-005 rst_in  input  1: asynchronous, active-low reset.
REQ-006 pc_src_in  input  1: redirect strobe (branch/jump taken), one cycle.
REQ-007 pc_branch_in  input  WIDTH: redirect target.
REQ-008 imem_req_valid_out  output  1: fetch request valid.
REQ-009 imem_req_ready_in  input  1: memory accepts request.
REQ-010 imem_addr_out  output  WIDTH: fetch address.
REQ-011 imem_rsp_valid_in  input  1: response valid; responses return in order, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data_in  input  WIDTH: response instruction.
REQ-013 instr_valid_out  output  1: decode-side instruction valid.
REQ-014 instr_ready_in  input  1: decode accepts instruction.
REQ-015 instr_out  output  WIDTH: instruction to decode.
REQ-016 instr_pc_out  output  WIDTH: PC of instr_out.
REQ-017 pc_current_out  output  WIDTH: next PC to be requested.

Function
REQ-018 Request fire = imem_req_valid_out AND imem_req_ready_in; on fire, pc_current_out <= pc_current_out + 4 (modulo 2^WIDTH, wraps silently).
REQ-019 imem_addr_out SHALL equal pc_current_out combinationally.
REQ-020 imem_req_valid_out = NOT pc_src_in AND (queue_count + inflight_count < DEPTH); credit rule guarantees a queue slot for every in-flight response.
REQ-021 inflight_count: +1 on fire, -1 on any response (kept or dropped), unchanged when both occur; range 0..DEPTH.
REQ-022 Response with discard_count = 0 SHALL be pushed to the queue with tag rsp_pc; rsp_pc then advances by 4.
REQ-023 Response with discard_count > 0 SHALL be dropped; discard_count decrements.
REQ-024 Redirect (pc_src_in = 1): pc_current_out and rsp_pc <= {pc_branch_in[WIDTH-1:2], 2'b00}; queue flushed; discard_count <= inflight_count minus 1 if a response arrives that same cycle (that response is dropped), else inflight_count.
REQ-025 Redirect has priority over pop and push in the same cycle; no request is issued in the redirect cycle; first fetch of target issues the following cycle.
REQ-026 Queue output is registered: a kept response is visible on instr_valid_out the cycle after imem_rsp_valid_in.
REQ-027 instr_valid_out = queue non-empty; pop on instr_valid_out AND instr_ready_in; simultaneous push and pop at any occupancy SHALL preserve order and count.
REQ-028 Back-to-back redirects SHALL accumulate correctly: discard_count never exceeds DEPTH and stale responses never reach the queue.

Reset
REQ-029 While rst_in = 0: pc_current_out = rsp_pc = RESET_PC; counts zero; imem_req_valid_out = 0; instr_valid_out = 0; instr_out and instr_pc_out = 0.
REQ-030 Reset assertion mid-operation SHALL abort all tracking immediately; responses to pre-reset requests are the memory's responsibility to suppress.
REQ-031 First request SHALL issue in the first cycle after rst_in deasserts, provided imem_req_ready_in = 1.

Structure
REQ-032 Package fetch_pkg SHALL hold RESET_PC default, PC_INCR = 4 and the counter-width function (clog2(DEPTH+1)).
REQ-033 Sub-module fetch_fifo (DEPTH x {pc, instr}, synchronous flush, registered output) SHALL implement the queue; counters and PC logic live in fetch_unit.

Verification
REQ-034 Reset, ready=1, 1-cycle memory, decode ready=1 -> addresses 0,4,8,...; instr_pc_out 0,4,8 in order, one instruction per cycle steady state.
REQ-035 Decode ready=0 with DEPTH=4 -> exactly 4 requests issued, then imem_req_valid_out=0 until a pop; no response lost.
REQ-036 3-cycle memory with 3 in flight, pc_src_in=1 with target 0x100 -> 3 responses dropped; first instr_pc_out = 0x100.
REQ-037 Redirect in same cycle as a response and a pop -> queue empty next cycle; discard_count = inflight - 1; next kept PC = target.
REQ-038 pc_branch_in=0x103 -> fetch address 0x100; PC at 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-039 rst_in low mid-stream with full queue -> all outputs at reset values asynchronously; restart fetches RESET_PC.
